// File: rtl/mandelbrot_pkg.sv
// +-----------------------------------------------------------------------------
// | mandelbrot_pkg
// | Shared types and defaults for the Mandelbrot iteration sequencer.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package mandelbrot_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_CTR_WIDTH = 8;
  // 1.0 in the 2.(WIDTH-2) fixed-point format
  localparam int ONE               = 1 << (DEFAULT_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mandelbrot_iterator.sv
// +-----------------------------------------------------------------------------
// | mandelbrot_iterator
// | Per-pixel iteration sequencer driving an external single-step Mandelbrot ALU.
// | Optional macro MANDELBROT_ITER_FIXPOINT_EN: early stop on fixed-point orbits.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module mandelbrot_iterator
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CTR_WIDTH = DEFAULT_CTR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_cr,
  input  logic [WIDTH-1:0]     in_ci,
  input  logic [CTR_WIDTH-1:0] in_max_iter,
  output logic [WIDTH-1:0]     alu_cr,
  output logic [WIDTH-1:0]     alu_ci,
  output logic [WIDTH-1:0]     alu_zr,
  output logic [WIDTH-1:0]     alu_zi,
  input  logic [WIDTH-1:0]     alu_zr_next,
  input  logic [WIDTH-1:0]     alu_zi_next,
  input  logic                 alu_size,
  input  logic                 alu_overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTR_WIDTH-1:0] out_count,
  output logic                 out_escaped
);

  state_t               state_q;
  logic [WIDTH-1:0]     cr_q, ci_q, zr_q, zi_q;
  logic [CTR_WIDTH-1:0] iter_q, max_iter_q, count_q;
  logic                 escaped_q;
  logic                 fix_d;
  logic [CTR_WIDTH-1:0] iter_d;

`ifdef MANDELBROT_ITER_FIXPOINT_EN
  assign fix_d = (alu_zr_next == zr_q) && (alu_zi_next == zi_q);
`else
  assign fix_d = 1'b0;
`endif

  // A fixed point jumps the counter to the limit so the normal limit path reports it.
  assign iter_d = fix_d ? max_iter_q : iter_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cr_q       <= '0;
      ci_q       <= '0;
      zr_q       <= '0;
      zi_q       <= '0;
      iter_q     <= '0;
      max_iter_q <= '0;
      count_q    <= '0;
      escaped_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cr_q       <= in_cr;
            ci_q       <= in_ci;
            max_iter_q <= in_max_iter;
            zr_q       <= '0;
            zi_q       <= '0;
            iter_q     <= '0;
            if (in_max_iter == '0) begin
              state_q   <= DONE;
              count_q   <= '0;
              escaped_q <= 1'b0;
            end else begin
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          // The limit is checked one cycle after the last update, so it wins over escape.
          if (iter_q == max_iter_q) begin
            state_q   <= DONE;
            count_q   <= max_iter_q;
            escaped_q <= 1'b0;
          end else if (alu_size || alu_overflow) begin
            state_q   <= DONE;
            count_q   <= iter_q;
            escaped_q <= 1'b1;
          end else begin
            zr_q   <= alu_zr_next;
            zi_q   <= alu_zi_next;
            iter_q <= iter_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_count   = count_q;
  assign out_escaped = escaped_q;
  assign alu_cr      = cr_q;
  assign alu_ci      = ci_q;
  assign alu_zr      = zr_q;
  assign alu_zi      = zi_q;

endmodule

`default_nettype wire

// File: tb/tb_mandelbrot_iterator.sv
// +-----------------------------------------------------------------------------
// | tb_mandelbrot_iterator
// | Self-checking bench with a behavioural ALU and an iteration reference model.
// | Revision: 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mandelbrot_iterator;
  import mandelbrot_pkg::*;

  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int FRAC = W - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_cr, in_ci;
  logic [CW-1:0] in_max_iter;
  logic [W-1:0]  alu_cr, alu_ci, alu_zr, alu_zi, alu_zr_next, alu_zi_next;
  logic          alu_size, alu_overflow;
  logic          out_valid, out_ready;
  logic [CW-1:0] out_count;
  logic          out_escaped;

  int n_checks = 0;
  int n_fail   = 0;

  mandelbrot_iterator #(.WIDTH(W), .CTR_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cr(in_cr), .in_ci(in_ci), .in_max_iter(in_max_iter),
    .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi),
    .alu_zr_next(alu_zr_next), .alu_zi_next(alu_zi_next),
    .alu_size(alu_size), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_escaped(out_escaped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [31:0] nr;
    logic signed [31:0] ni;
    logic               sz;
    logic               ov;
  } alu_res_t;

  // One step z^2 + c in plain integer arithmetic on signed fixed-point values.
  function automatic alu_res_t alu_step(input int cr, input int ci, input int zr, input int zi);
    alu_res_t r;
    r.nr = ((zr * zr - zi * zi) >>> FRAC) + cr;
    r.ni = ((2 * zr * zi) >>> FRAC) + ci;
    r.sz = (zr * zr + zi * zi) > (4 * ONE * ONE);
    r.ov = (r.nr > 127) || (r.nr < -128) || (r.ni > 127) || (r.ni < -128);
    return r;
  endfunction

  alu_res_t alu_r;
  always_comb begin
    alu_r        = alu_step(int'($signed(alu_cr)), int'($signed(alu_ci)),
                            int'($signed(alu_zr)), int'($signed(alu_zi)));
    alu_zr_next  = alu_r.nr[W-1:0];
    alu_zi_next  = alu_r.ni[W-1:0];
    alu_size     = alu_r.sz;
    alu_overflow = alu_r.ov;
  end

  // Reference: iterate the recurrence; latency = completed iterations + 2 (or 1 for limit 0).
  task automatic model(input int cr, input int ci, input int mi,
                       output int cnt, output bit esc, output int lat);
    int zr, zi;
    alu_res_t r;
    zr = 0; zi = 0;
    cnt = mi; esc = 1'b0; lat = mi + 2;
    if (mi == 0) begin
      lat = 1;
      return;
    end
    for (int k = 0; k < mi; k++) begin
      r = alu_step(cr, ci, zr, zi);
      if (r.sz || r.ov) begin
        cnt = k; esc = 1'b1; lat = k + 2;
        return;
      end
`ifdef MANDELBROT_ITER_FIXPOINT_EN
      if (r.nr == zr && r.ni == zi) begin
        cnt = mi; esc = 1'b0; lat = k + 3;
        return;
      end
`endif
      zr = r.nr; zi = r.ni;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_point(input string nm, input logic [7:0] cr, input logic [7:0] ci,
                           input logic [7:0] mi, input int ecnt, input bit eesc, input int elat);
    int n;
    @(negedge clk);
    check({nm, "/in_ready_pre"}, int'(in_ready), 1);
    in_valid = 1'b1; in_cr = cr; in_ci = ci; in_max_iter = mi; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_cr = W'($urandom); in_ci = W'($urandom); in_max_iter = CW'($urandom);
    n = 1;
    while (!out_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "/out_valid"}, int'(out_valid), 1);
    check({nm, "/count"}, int'(out_count), ecnt);
    check({nm, "/escaped"}, int'(out_escaped), int'(eesc));
    check({nm, "/latency"}, n, elat);
    @(posedge clk); #1;
    check({nm, "/in_ready_post"}, int'(in_ready), 1);
  endtask

  typedef struct {
    string      nm;
    logic [7:0] cr, ci, mi;
    int         cnt;
    bit         esc;
    int         lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, lat;
    bit esc;
    logic [7:0] cr, ci, mi;

`ifdef MANDELBROT_ITER_FIXPOINT_EN
    tbl[0] = '{"origin16",   8'd0,   8'd0,   8'd16,  16,  1'b0, 3};
    tbl[1] = '{"origin255",  8'd0,   8'd0,   8'd255, 255, 1'b0, 3};
`else
    tbl[0] = '{"origin16",   8'd0,   8'd0,   8'd16,  16,  1'b0, 18};
    tbl[1] = '{"origin255",  8'd0,   8'd0,   8'd255, 255, 1'b0, 257};
`endif
    tbl[2] = '{"minus2",     8'h80,  8'd0,   8'd16,  1,   1'b1, 3};
    tbl[3] = '{"one_plus_i", 8'd64,  8'd64,  8'd8,   1,   1'b1, 3};
    tbl[4] = '{"limit0",     8'd37,  8'hA6,  8'd0,   0,   1'b0, 1};
    tbl[5] = '{"limit1",     8'd0,   8'd0,   8'd1,   1,   1'b0, 3};
    tbl[6] = '{"corner",     8'd127, 8'd127, 8'd50,  1,   1'b1, 3};
    tbl[7] = '{"period2",    8'hC0,  8'd0,   8'd10,  10,  1'b0, 12};

    rst = 1'b1; in_valid = 1'b0; in_cr = '0; in_ci = '0; in_max_iter = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/in_ready", int'(in_ready), 1);
    check("reset/out_valid", int'(out_valid), 0);
    check("reset/count", int'(out_count), 0);
    check("reset/escaped", int'(out_escaped), 0);
    check("reset/alu_zr", int'(alu_zr), 0);
    check("reset/alu_cr", int'(alu_cr), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_point(tbl[i].nm, tbl[i].cr, tbl[i].ci, tbl[i].mi, tbl[i].cnt, tbl[i].esc, tbl[i].lat);

    // Limit 0 keeps z at zero while c is latched.
    @(negedge clk);
    in_valid = 1'b1; in_cr = 8'd37; in_ci = 8'hA6; in_max_iter = 8'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_cr = 8'd1; in_ci = 8'd2;
    @(negedge clk);
    check("lim0/alu_zr", int'(alu_zr), 0);
    check("lim0/alu_zi", int'(alu_zi), 0);
    check("lim0/alu_cr", int'(alu_cr), 37);
    check("lim0/alu_ci", int'(alu_ci), 8'hA6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("lim0/consumed", int'(out_valid), 0);

    // Back-pressure: result held, in_valid pulses ignored.
    @(negedge clk);
    in_valid = 1'b1; in_cr = 8'd64; in_ci = 8'd64; in_max_iter = 8'd8; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall/out_valid", int'(out_valid), 1);
      check("stall/count", int'(out_count), 1);
      check("stall/escaped", int'(out_escaped), 1);
      check("stall/in_ready", int'(in_ready), 0);
      in_valid = k[0]; in_cr = W'($urandom); in_ci = W'($urandom); in_max_iter = 8'd0;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall/consumed", int'(out_valid), 0);
    check("stall/in_ready_after", int'(in_ready), 1);

    // Reset in the middle of an iteration run.
    @(negedge clk);
    in_valid = 1'b1; in_cr = 8'd16; in_ci = 8'd0; in_max_iter = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("midrst/alu_zr_pre", int'(alu_zr), 22);
    check("midrst/in_ready_pre", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_cr = 8'h55; in_max_iter = 8'd3;
    #1;
    check("midrst/out_valid", int'(out_valid), 0);
    check("midrst/in_ready", int'(in_ready), 1);
    check("midrst/alu_zr", int'(alu_zr), 0);
    check("midrst/alu_cr", int'(alu_cr), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    run_point("post_rst", 8'h80, 8'd0, 8'd16, 1, 1'b1, 3);

    // Randomized points against the reference model.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 1) begin
        cr = 8'($urandom_range(0, 255));
        ci = 8'($urandom_range(0, 255));
      end else begin
        cr = 8'(int'($urandom_range(0, 96)) - 48);
        ci = 8'(int'($urandom_range(0, 96)) - 48);
      end
      mi = 8'($urandom_range(0, 40));
      model(int'($signed(cr)), int'($signed(ci)), int'(mi), cnt, esc, lat);
      run_point($sformatf("rand%0d", i), cr, ci, mi, cnt, esc, lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
